// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Core-side request/response bundle between the pipeline's instruction-fetch
//   and load/store ports and mem_arbiter.
//
//   Handshake: a request transfers in the cycle where valid && ready. The
//   requester holds valid, addr, wstrb and wdata stable until ready. ready is
//   high only in the grant cycle and never without its valid. The response
//   (rvalid + rdata) arrives exactly one cycle after the grant and has no
//   backpressure.
//
//   Ports (signals):
//     if_valid/if_addr               fetch request          (master -> slave)
//     if_ready/if_rvalid/if_rdata    fetch accept/response  (slave -> master)
//     ls_valid/ls_addr/ls_wstrb/ls_wdata  load/store request (master -> slave)
//     ls_ready/ls_rvalid/ls_rdata    load/store accept/response (slave -> master)
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                      if_valid;
  logic [ADDR_WIDTH-1:0]     if_addr;
  logic                      if_ready;
  logic                      if_rvalid;
  logic [DATA_WIDTH-1:0]     if_rdata;

  logic                      ls_valid;
  logic [ADDR_WIDTH-1:0]     ls_addr;
  logic [DATA_WIDTH/8-1:0]   ls_wstrb;
  logic [DATA_WIDTH-1:0]     ls_wdata;
  logic                      ls_ready;
  logic                      ls_rvalid;
  logic [DATA_WIDTH-1:0]     ls_rdata;

  // Core pipeline side.
  modport master (
    output if_valid, if_addr,
    input  if_ready, if_rvalid, if_rdata,
    output ls_valid, ls_addr, ls_wstrb, ls_wdata,
    input  ls_ready, ls_rvalid, ls_rdata
  );

  // Arbiter side.
  modport slave (
    input  if_valid, if_addr,
    output if_ready, if_rvalid, if_rdata,
    input  ls_valid, ls_addr, ls_wstrb, ls_wdata,
    output ls_ready, ls_rvalid, ls_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port BRAM between the fetch port and the load/store
//   port. At most one grant per cycle, round-robin on conflict, fixed one-cycle
//   read latency, and a free-running count of contention cycles.
//
//   Ports:
//     clk, resetn     clock, asynchronous active-low reset
//     bus             core request/response bundle (mem_arbiter_if.slave)
//     bram_en/we/addr/wdata   BRAM port drive
//     bram_rdata      BRAM registered read data (valid one cycle after en)
//     conflicts       cycles with both valids high, wraps modulo 2^32
//     dbg_rsp_sel     response-owner register (none / IF / LS)
//     dbg_last_win    winner of the most recent conflict (0 = IF, 1 = LS)
module mem_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  mem_arbiter_if.slave            bus,
  output logic                    bram_en,
  output logic [DATA_WIDTH/8-1:0] bram_we,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic [DATA_WIDTH-1:0]   bram_wdata,
  input  logic [DATA_WIDTH-1:0]   bram_rdata,
  output logic [31:0]             conflicts,
  output logic [1:0]              dbg_rsp_sel,
  output logic                    dbg_last_win
);

  typedef enum logic [1:0] {
    RSP_NONE = 2'b00,
    RSP_IF   = 2'b01,
    RSP_LS   = 2'b10
  } rsp_sel_t;

  typedef enum logic {
    WIN_IF = 1'b0,
    WIN_LS = 1'b1
  } win_t;

  rsp_sel_t    rsp_sel, rsp_sel_next;
  win_t        last_win, last_win_next;
  logic [31:0] conflict_cnt, conflict_cnt_next;

  logic conflict;
  logic grant_if;
  logic grant_ls;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_sel      <= RSP_NONE;
      last_win     <= WIN_LS;   // so fetch wins the first conflict
      conflict_cnt <= 32'd0;
    end else begin
      rsp_sel      <= rsp_sel_next;
      last_win     <= last_win_next;
      conflict_cnt <= conflict_cnt_next;
    end
  end

  always_comb begin
    conflict          = bus.if_valid && bus.ls_valid;
    // On conflict the port that did not win last time takes the grant.
    grant_if          = bus.if_valid && (!bus.ls_valid || (last_win == WIN_LS));
    grant_ls          = bus.ls_valid && (!bus.if_valid || (last_win == WIN_IF));

    rsp_sel_next      = RSP_NONE;
    last_win_next     = last_win;
    conflict_cnt_next = conflict_cnt;

    bram_en    = 1'b0;
    bram_we    = '0;
    bram_addr  = bus.if_addr;
    bram_wdata = bus.ls_wdata;

    if (grant_if) begin
      rsp_sel_next = RSP_IF;
      bram_en      = 1'b1;
      bram_addr    = bus.if_addr;
    end else if (grant_ls) begin
      rsp_sel_next = RSP_LS;
      bram_en      = 1'b1;
      bram_we      = bus.ls_wstrb;
      bram_addr    = bus.ls_addr;
    end

    // last_win only moves on contended cycles; an uncontested grant does not
    // change who is owed the next conflict.
    if (conflict) begin
      last_win_next     = grant_if ? WIN_IF : WIN_LS;
      conflict_cnt_next = conflict_cnt + 32'd1;
    end
  end

  // Both read-data outputs come straight from the BRAM; rvalid qualifies them.
  assign bus.if_ready  = grant_if;
  assign bus.ls_ready  = grant_ls;
  assign bus.if_rvalid = (rsp_sel == RSP_IF);
  assign bus.ls_rvalid = (rsp_sel == RSP_LS);
  assign bus.if_rdata  = bram_rdata;
  assign bus.ls_rdata  = bram_rdata;

  assign conflicts    = conflict_cnt;
  assign dbg_rsp_sel  = rsp_sel;
  assign dbg_last_win = last_win;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a behavioural 1024x32 BRAM
//   (registered read, byte-write enables). Inputs change 1 time unit after
//   the rising edge; outputs are sampled 1 time unit later.
module tb_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk;
  logic          resetn;
  logic          bram_en;
  logic [3:0]    bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wdata;
  logic [DW-1:0] bram_rdata;
  logic [31:0]   conflicts;
  logic [1:0]    dbg_rsp_sel;
  logic          dbg_last_win;

  int checks;
  int errors;

  logic [31:0] mem [0:1023];
  logic [31:0] fetch_exp [4];
  logic [5:0]  exp_if_pattern;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .bus          (bus),
    .bram_en      (bram_en),
    .bram_we      (bram_we),
    .bram_addr    (bram_addr),
    .bram_wdata   (bram_wdata),
    .bram_rdata   (bram_rdata),
    .conflicts    (conflicts),
    .dbg_rsp_sel  (dbg_rsp_sel),
    .dbg_last_win (dbg_last_win)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: read-first, registered read data.
  always @(posedge clk) begin
    if (bram_en) begin
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
      bram_rdata <= mem[bram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.if_valid = 1'b0;
    bus.if_addr  = '0;
    bus.ls_valid = 1'b0;
    bus.ls_addr  = '0;
    bus.ls_wstrb = 4'h0;
    bus.ls_wdata = 32'h0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bram_rdata = 32'h0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0] = 32'hA000_0000;
    mem[1] = 32'hA111_0001;
    mem[2] = 32'hA222_0002;
    mem[3] = 32'hA333_0003;
    mem[5] = 32'h0000_0013;
    mem[8] = 32'h1111_1111;
    fetch_exp[0] = 32'hA000_0000;
    fetch_exp[1] = 32'hA111_0001;
    fetch_exp[2] = 32'hA222_0002;
    fetch_exp[3] = 32'hA333_0003;
    // IF granted on conflict cycles 0, 2, 4 (bit i = cycle i)
    exp_if_pattern = 6'b010101;

    idle_inputs();
    resetn = 1'b0;

    // ---- reset state
    tick();
    tick();
    chk("rst_if_ready",  32'(bus.if_ready),  32'd0);
    chk("rst_ls_ready",  32'(bus.ls_ready),  32'd0);
    chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    chk("rst_ls_rvalid", 32'(bus.ls_rvalid), 32'd0);
    chk("rst_bram_en",   32'(bram_en),       32'd0);
    chk("rst_bram_we",   32'(bram_we),       32'd0);
    chk("rst_conflicts", conflicts,          32'd0);
    chk("rst_rsp_sel",   32'(dbg_rsp_sel),   32'd0);
    chk("rst_last_win",  32'(dbg_last_win),  32'd1);
    @(negedge clk);
    resetn = 1'b1;

    // ---- fetch only, word 5
    tick();
    bus.if_valid = 1'b1;
    bus.if_addr  = 10'd5;
    #1;
    chk("f_if_ready",  32'(bus.if_ready), 32'd1);
    chk("f_ls_ready",  32'(bus.ls_ready), 32'd0);
    chk("f_bram_en",   32'(bram_en),      32'd1);
    chk("f_bram_addr", 32'(bram_addr),    32'd5);
    chk("f_bram_we",   32'(bram_we),      32'd0);
    tick();
    bus.if_valid = 1'b0;
    #1;
    chk("f_if_rvalid", 32'(bus.if_rvalid), 32'd1);
    chk("f_if_rdata",  bus.if_rdata,       32'h0000_0013);
    chk("f_ls_rvalid", 32'(bus.ls_rvalid), 32'd0);
    chk("f_conflicts", conflicts,          32'd0);
    chk("f_if_ready_low", 32'(bus.if_ready), 32'd0);
    tick();
    #1;
    chk("f_if_rvalid_once", 32'(bus.if_rvalid), 32'd0);

    // ---- store then load to word 8
    bus.ls_valid = 1'b1;
    bus.ls_addr  = 10'd8;
    bus.ls_wstrb = 4'h3;
    bus.ls_wdata = 32'hDEAD_BEEF;
    #1;
    chk("st_ls_ready",   32'(bus.ls_ready), 32'd1);
    chk("st_bram_we",    32'(bram_we),      32'h3);
    chk("st_bram_addr",  32'(bram_addr),    32'd8);
    chk("st_bram_wdata", bram_wdata,        32'hDEAD_BEEF);
    tick();
    bus.ls_wstrb = 4'h0;
    #1;
    chk("st_ack_rvalid", 32'(bus.ls_rvalid), 32'd1);
    chk("ld_ls_ready",   32'(bus.ls_ready),  32'd1);
    chk("ld_bram_we",    32'(bram_we),       32'd0);
    tick();
    idle_inputs();
    #1;
    chk("ld_rvalid", 32'(bus.ls_rvalid), 32'd1);
    chk("ld_rdata",  bus.ls_rdata,       32'h1111_BEEF);
    tick();
    #1;
    chk("ld_rvalid_once", 32'(bus.ls_rvalid), 32'd0);

    // ---- sustained conflict after a fresh reset
    #2;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    tick();
    bus.if_valid = 1'b1;
    bus.if_addr  = 10'd0;
    bus.ls_valid = 1'b1;
    bus.ls_addr  = 10'd1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("sc_if_ready_%0d", i), 32'(bus.if_ready), 32'(exp_if_pattern[i]));
      chk($sformatf("sc_ls_ready_%0d", i), 32'(bus.ls_ready), 32'(!exp_if_pattern[i]));
      chk($sformatf("sc_both_%0d", i), 32'(bus.if_ready && bus.ls_ready), 32'd0);
      chk($sformatf("sc_cnt_%0d", i), conflicts, 32'(i));
      tick();
    end
    idle_inputs();
    #1;
    chk("sc_conflicts", conflicts, 32'd6);
    chk("sc_last_rsp_ls", 32'(bus.ls_rvalid), 32'd1);

    // ---- back-to-back fetches 0..3
    tick();
    bus.if_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.if_addr = 10'(i);
      #1;
      chk($sformatf("bb_if_ready_%0d", i), 32'(bus.if_ready), 32'd1);
      if (i > 0) begin
        chk($sformatf("bb_rvalid_%0d", i - 1), 32'(bus.if_rvalid), 32'd1);
        chk($sformatf("bb_rdata_%0d", i - 1), bus.if_rdata, fetch_exp[i-1]);
      end
      tick();
    end
    idle_inputs();
    #1;
    chk("bb_rvalid_3", 32'(bus.if_rvalid), 32'd1);
    chk("bb_rdata_3",  bus.if_rdata,       fetch_exp[3]);
    tick();
    #1;
    chk("bb_rvalid_end", 32'(bus.if_rvalid), 32'd0);

    // ---- reset in the cycle after a load grant
    bus.ls_valid = 1'b1;
    bus.ls_addr  = 10'd8;
    #1;
    chk("rm_ls_ready", 32'(bus.ls_ready), 32'd1);
    tick();
    idle_inputs();
    #2;
    resetn = 1'b0;
    #1;
    chk("rm_ls_rvalid_async", 32'(bus.ls_rvalid), 32'd0);
    chk("rm_conflicts",       conflicts,          32'd0);
    chk("rm_last_win",        32'(dbg_last_win),  32'd1);
    tick();
    chk("rm_ls_rvalid_held",  32'(bus.ls_rvalid), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    bus.if_valid = 1'b1;
    bus.ls_valid = 1'b1;
    #1;
    chk("rm_first_if", 32'(bus.if_ready), 32'd1);
    chk("rm_first_ls", 32'(bus.ls_ready), 32'd0);
    tick();
    idle_inputs();
    #1;
    chk("rm_conflicts_1", conflicts, 32'd1);

    // ---- counter wrap
    force dut.conflict_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.conflict_cnt;
    bus.if_valid = 1'b1;
    bus.ls_valid = 1'b1;
    #1;
    chk("wr_preload",  conflicts,           32'hFFFF_FFFF);
    chk("wr_ls_ready", 32'(bus.ls_ready),   32'd1);
    tick();
    idle_inputs();
    #1;
    chk("wr_conflicts", conflicts, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
